// File: rtl/mc_control_pkg.sv
// -----------------------------------------------------------------------------
// mc_control_pkg
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode and funct constants, ALU operation codes and the mux-select codes
// driven onto the datapath.
// Optional build macro: MC_CONTROL_ADDI_EN. The ADDI_EX/ADDI_WB encodings
// are always declared here. They are only reachable when the macro is defined.
// -----------------------------------------------------------------------------
package mc_control_pkg;

    // Controller states; the numeric values are visible on the debug port.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// -----------------------------------------------------------------------------
// mc_control_if
// Bundle between the control unit and the multi-cycle datapath.
//   opcode/funct/zero : IR fields and ALU zero flag, datapath -> control
//   pc_en ... illegal  : per-state control strobes and mux selects
//   state              : current controller state for debug
// Modports: master = control unit, slave = datapath.
// -----------------------------------------------------------------------------
interface mc_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, illegal, state
    );

endinterface

// File: rtl/mc_control_alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Combinational R-type funct decoder.
//   funct       in  6  IR[5:0]
//   alu_op      out 4  ALU operation (add for unknown funct)
//   funct_legal out 1  high when funct is a supported R-type operation
// -----------------------------------------------------------------------------
module alu_control
    import mc_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_legal
);

    // Unknown function codes fall back to add so the ALU sees a harmless op
    // while the controller flags the instruction as illegal.
    always_comb begin
        alu_op      = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            FN_NOR:  alu_op = ALU_NOR;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multi-cycle MIPS control unit. Moore FSM that sequences the shared datapath
// (PC/IR, unified memory, register file, ALU) one state per clock.
//   clock  in  system clock, all state changes on posedge
//   reset  in  synchronous, active-high; forces FETCH and masks all strobes
//   bus    mc_control_if.master: opcode/funct/zero in, control signals out
// Parameter MEM_LAT (1..8): cycles spent in FETCH and in MEM_READ.
// Optional build macro: MC_CONTROL_ADDI_EN enables the addi instruction
// (ADDI_EX/ADDI_WB states). Without it, addi decodes as illegal.
// -----------------------------------------------------------------------------
module mc_control
    import mc_control_pkg::*;
#(
    parameter int MEM_LAT = 1
)(
    input  logic          clock,
    input  logic          reset,
    mc_control_if.master  bus
);

    localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       pc_write, pc_write_cond;
    logic       i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic       illegal;

    logic [3:0] fn_alu_op;
    logic       fn_legal;
    logic       cnt_done;

    alu_control u_alu_control (
        .funct       (bus.funct),
        .alu_op      (fn_alu_op),
        .funct_legal (fn_legal)
    );

    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Moore outputs. The latency counter only advances while
    // dwelling in FETCH or MEM_READ and is cleared by every other path.
    always_comb begin
        state_d       = FETCH;
        cnt_d         = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_AND;
        illegal       = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (cnt_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = FETCH;
                end
            end

            DECODE: begin
                alu_src_b = SRCB_IMMSH;
                alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE: state_d = EXECUTE;
                    OP_LW,
                    OP_SW:    state_d = MEM_ADDR;
                    OP_BEQ:   state_d = BRANCH;
                    OP_J:     state_d = JUMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI:  state_d = ADDI_EX;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end

            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (cnt_done) begin
                    state_d = MEM_WB;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = MEM_READ;
                end
            end

            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end

            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end

            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = fn_alu_op;
                if (fn_legal) begin
                    state_d = R_WB;
                end else begin
                    illegal = 1'b1;
                end
            end

            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end

            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end

            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end

`ifdef MC_CONTROL_ADDI_EN
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = ADDI_WB;
            end

            ADDI_WB: begin
                reg_write = 1'b1;
            end
`endif

            default: state_d = FETCH;
        endcase
    end

    // Strobes are masked by reset combinationally: the state register only
    // returns to FETCH on the next edge, so the cycle in which reset rises
    // must not be allowed to write anything.
    assign bus.pc_en      = ~reset & (pc_write | (pc_write_cond & bus.zero));
    assign bus.mem_read   = ~reset & mem_read;
    assign bus.mem_write  = ~reset & mem_write;
    assign bus.ir_write   = ~reset & ir_write;
    assign bus.reg_write  = ~reset & reg_write;
    assign bus.illegal    = ~reset & illegal;

    assign bus.i_or_d     = i_or_d;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_source  = pc_source;
    assign bus.alu_op     = alu_op;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
// Randomized instruction stream for mc_control. Each instruction is expanded
// into its expected per-cycle state/control sequence and queued. A monitor
// pops one entry per cycle and compares it against the DUT.
// Honors MC_CONTROL_ADDI_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mc_control;

    localparam int MEM_LAT = 3;
    localparam int PERIOD  = 10;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;

    logic clock;
    logic reset;
    mc_control_if bus();

    mc_control #(.MEM_LAT(MEM_LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cycleNo = 0;
    logic [5:0] legalFn[6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h27};

    initial begin
        clock = 1'b0;
        forever #(PERIOD / 2) clock = ~clock;
    end

    initial begin
        #(PERIOD * 50000);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // funct -> {legal, alu op}
    function automatic logic [4:0] aluFor(input logic [5:0] f);
        case (f)
            6'h24:   return {1'b1, 4'b0000};
            6'h25:   return {1'b1, 4'b0001};
            6'h20:   return {1'b1, 4'b0010};
            6'h22:   return {1'b1, 4'b0110};
            6'h2a:   return {1'b1, 4'b0111};
            6'h27:   return {1'b1, 4'b1100};
            default: return {1'b0, 4'b0010};
        endcase
    endfunction

    function automatic bit opSupported(input logic [5:0] op);
        bit ok;
        ok = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) ||
             (op == 6'h04) || (op == 6'h02);
`ifdef MC_CONTROL_ADDI_EN
        ok = ok || (op == 6'h08);
`endif
        return ok;
    endfunction

    // Expected control vector for one cycle, from the per-state output table.
    function automatic logic [17:0] expCtrl(input int st, input bit lastF,
                                            input bit z, input logic [5:0] f,
                                            input bit badOp, input bit rst);
        logic       pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, sa, ill, pcen;
        logic [1:0] sb, ps;
        logic [3:0] op;
        logic [4:0] a;
        pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; rdst = 0;
        m2r = 0; rw = 0; sa = 0; ill = 0; sb = 2'b00; ps = 2'b00; op = 4'b0000;
        a = aluFor(f);
        case (st)
            0:  begin mr = 1; sb = 2'b01; op = 4'b0010; irw = lastF; pcw = lastF; end
            1:  begin sb = 2'b11; op = 4'b0010; ill = badOp; end
            2:  begin sa = 1; sb = 2'b10; op = 4'b0010; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; op = a[3:0]; ill = ~a[4]; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; op = 4'b0110; pcwc = 1; ps = 2'b01; end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; op = 4'b0010; end
            11: begin rw = 1; end
            default: ;
        endcase
        pcen = pcw | (pcwc & z);
        if (rst) begin
            pcen = 0; mr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        end
        return {pcen, iord, mr, mw, irw, rdst, m2r, rw, sa, sb, ps, op, ill};
    endfunction

    task automatic pushCycle(input int st, input bit lastF, input bit rst,
                             input logic [5:0] op, input logic [5:0] f,
                             input bit badOp, input int zMode);
        exp_t e;
        @(posedge clock);
        #1;
        reset      = rst;
        bus.opcode = op;
        bus.funct  = f;
        bus.zero   = (zMode == 2) ? 1'($urandom_range(0, 1)) : (zMode == 1);
        e.st   = 4'(st);
        e.ctrl = expCtrl(st, lastF, bus.zero, f, badOp, rst);
        expQ.push_back(e);
    endtask

    // kind: 0 R legal, 1 R bad funct, 2 lw, 3 sw, 4 beq, 5 j, 6 addi, 7 bad op.
    // abortAt: sequence index at which reset is raised for resetLen cycles.
    // zMode: 0/1 force zero, 2 random. opSel/fSel: -1 random, else forced.
    task automatic applyStimulus(input int kind, input int abortAt,
                                 input int resetLen, input int zMode,
                                 input int opSel, input int fSel);
        logic [5:0] op, f;
        logic [4:0] a;
        bit         badOp;
        int         sts[$];
        bit         lst[$];
        f = 6'($urandom_range(0, 63));
        op = 6'h00;
        case (kind)
            0: f = legalFn[$urandom_range(0, 5)];
            1: begin
                a = aluFor(f);
                while (a[4]) begin
                    f = 6'($urandom_range(0, 63));
                    a = aluFor(f);
                end
            end
            2: op = 6'h23;
            3: op = 6'h2b;
            4: op = 6'h04;
            5: op = 6'h02;
            6: op = 6'h08;
            default: begin
                op = 6'($urandom_range(0, 63));
                while ((op == 6'h00) || (op == 6'h23) || (op == 6'h2b) ||
                       (op == 6'h04) || (op == 6'h02) || (op == 6'h08))
                    op = 6'($urandom_range(0, 63));
            end
        endcase
        if (opSel >= 0) op = 6'(opSel);
        if (fSel >= 0) f = 6'(fSel);
        badOp = !opSupported(op);

        for (int i = 0; i < MEM_LAT; i++) begin
            sts.push_back(0);
            lst.push_back(i == MEM_LAT - 1);
        end
        sts.push_back(1); lst.push_back(0);
        if (!badOp) begin
            case (op)
                6'h00: begin
                    a = aluFor(f);
                    sts.push_back(6); lst.push_back(0);
                    if (a[4]) begin sts.push_back(7); lst.push_back(0); end
                end
                6'h23: begin
                    sts.push_back(2); lst.push_back(0);
                    for (int i = 0; i < MEM_LAT; i++) begin
                        sts.push_back(3); lst.push_back(0);
                    end
                    sts.push_back(4); lst.push_back(0);
                end
                6'h2b: begin
                    sts.push_back(2); lst.push_back(0);
                    sts.push_back(5); lst.push_back(0);
                end
                6'h04: begin sts.push_back(8); lst.push_back(0); end
                6'h02: begin sts.push_back(9); lst.push_back(0); end
                6'h08: begin
                    sts.push_back(10); lst.push_back(0);
                    sts.push_back(11); lst.push_back(0);
                end
                default: ;
            endcase
        end

        for (int i = 0; i < sts.size(); i++) begin
            if (i == abortAt) begin
                for (int r = 0; r < resetLen; r++)
                    pushCycle((r == 0) ? sts[i] : 0, (r == 0) ? lst[i] : 1'b0,
                              1'b1, op, f, badOp, zMode);
                return;
            end
            pushCycle(sts[i], lst[i], 1'b0, op, f, badOp, zMode);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [17:0] act;
        act = {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
               bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
               bus.alu_src_b, bus.pc_source, bus.alu_op, bus.illegal};
        checks++;
        if (bus.state !== e.st) begin
            errors++;
            $display("[TB] FAIL state cycle=%0d actual=%0d expected=%0d",
                     cycleNo, bus.state, e.st);
        end
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL ctrl cycle=%0d state=%0d actual=%05h expected=%05h",
                     cycleNo, e.st, act, e.ctrl);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cycleNo++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int kind, abortAt, len;
        reset      = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clock);
        pushCycle(0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 0);

        applyStimulus(0, -1, 0, 2, -1, 6'h22);
        applyStimulus(0, MEM_LAT + 2, 3, 2, -1, 6'h20);
        applyStimulus(2, -1, 0, 2, -1, -1);
        applyStimulus(2, 1, 1, 2, -1, -1);
        applyStimulus(3, -1, 0, 2, -1, -1);
        applyStimulus(4, -1, 0, 1, -1, -1);
        applyStimulus(4, -1, 0, 0, -1, -1);
        applyStimulus(5, -1, 0, 2, -1, -1);
        applyStimulus(7, -1, 0, 2, 6'h3f, -1);
        applyStimulus(1, -1, 0, 2, -1, 6'h00);
        applyStimulus(6, -1, 0, 2, -1, -1);

        for (int n = 0; n < 200; n++) begin
            kind    = $urandom_range(0, 7);
            abortAt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, MEM_LAT + 1) : -1;
            len     = $urandom_range(1, 3);
            applyStimulus(kind, abortAt, len, 2, -1, -1);
        end

        @(negedge clock);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d expected=0 entries left", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
